imem_dmem_port_arbiter: RTL
===========================

// Module: imem_dmem_port_arbiter
// PURPOSE
//  Shares one single-port memory bus between the IF stage fetch (ice/iaddr) and the MEM stage data access.
//  Data has priority over fetch. Tracks each outstanding transaction with an FSM and a req/ack handshake.
//  Drives the pipeline stall bus while a requester waits, and discards a fetch that is flushed in flight.
//  Sits between if_stage/mem_stage and the external memory wrapper.
// PARAMETERS
//  ADDR_MASK  32'h1fff_ffff  mask applied to every outgoing address (kseg0/kseg1 -> physical)
//  TIMEOUT    16             max cycles from mem_req to mem_ack before bus_err; range 2..255
// PORTS
//  cpu_clk_50M  in   1            clock, rising edge
//  cpu_rst_n    in   1            reset, asynchronous, active-low
//  ice          in   1            fetch request (already gated by stall/flush in IF)
//  iaddr        in   32           fetch address
//  inst         out  32           fetched word, valid when inst_valid
//  inst_valid   out  1            1-cycle pulse: inst holds the fetched word
//  dce          in   1            data request from MEM stage
//  dwe          in   4            byte write enables; 0 = load
//  daddr        in   32           data address
//  din          in   32           store data
//  dm           out  32           load data, valid when dm_valid
//  dm_valid     out  1            1-cycle pulse: dm holds load data
//  flush        in   1            exception flush from CP0
//  stall_o      out  `STALL_BUS   [0]=hold PC, [1]=hold IF/ID, [2]=hold ID/EX, [3]=hold EX/MEM
//  bus_err      out  1            1-cycle pulse on timeout
//  mem_req      out  1            registered request, held until mem_ack
//  mem_we       out  4            registered byte enables
//  mem_addr     out  32           registered address = addr & ADDR_MASK
//  mem_wdata    out  32           registered store data
//  mem_rdata    in   32           read data, valid with mem_ack
//  mem_ack      in   1            1-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including mem_req, inst, dm, stall_o and the timeout counter.
//  States: IDLE, D_WAIT, I_WAIT, I_DRAIN.
//  IDLE, dce=1:
//   - latch mem_* from daddr/dwe/din; go to D_WAIT.
//   - stall_o=4'b1111 combinationally in the same cycle.
//  IDLE, dce=0, ice=1, iaddr[1:0]==0:
//   - latch fetch (mem_we=0); go to I_WAIT.
//   - stall_o=4'b0011 combinationally.
//  IDLE, ice=1 with misaligned iaddr: no bus cycle, no stall; inst=0 with inst_valid=1 (IF raises ADEL).
//  Simultaneous dce and ice: data wins; the fetch is re-requested by IF because it is stalled.
//  D_WAIT:
//   - stall_o=4'b1111 until mem_ack.
//   - In the ack cycle stall_o=0 and dm=mem_rdata with dm_valid=1 (load only); go to IDLE.
//  I_WAIT:
//   - stall_o=4'b0011 until mem_ack.
//   - In the ack cycle stall_o=0 and inst=mem_rdata with inst_valid=1; go to IDLE.
//  flush in I_WAIT (without ack): go to I_DRAIN. mem_req stays high, because a request is never withdrawn.
//  I_DRAIN: stall_o=0; wait for mem_ack; ack discarded (no inst_valid); then IDLE.
//  flush in IDLE: new requests are still accepted (IF gates ice itself).
//  flush in D_WAIT: transaction completes; store written; load data delivered but ignored upstream.
//  ack and flush in the same I_WAIT cycle: ack discarded; go to IDLE.
//  Minimum latency: request cycle N, mem_req high N+1, earliest ack N+1 -> data at N+1.
//  After any ack, IDLE takes one cycle before the next request (one bubble per access).
//  mem_req drops in the cycle after mem_ack.
//  Timeout counter:
//   - cleared on entry to a WAIT/DRAIN state; increments each cycle while mem_req=1.
//   - On reaching TIMEOUT: bus_err=1 for 1 cycle; mem_req drops; stall released; inst=0/dm=0 valid; go to IDLE.
//  Async reset mid-transaction: immediate return to reset values; the memory side must tolerate an abandoned req.
// STRUCTURE
//  defines.v: `STALL_BUS, `ARB_IDLE/`ARB_D_WAIT/`ARB_I_WAIT/`ARB_I_DRAIN (2-bit encodings), `STALL_ALL=4'b1111, `STALL_IF=4'b0011.
//  One sub-module: arb_wait_timer (8-bit counter with clear/enable/expire). The FSM and muxes stay here.
// TESTING
//  1. Fetch 0xBFC00000, ack after 3 cycles with 0x24080001:
//     mem_addr=0x1FC00000; stall_o=0011 for 3 cycles; inst=0x24080001 with inst_valid.
//  2. dce=1 (dwe=4'b1111, daddr=0x80000010, din=0xDEADBEEF) with ice=1 in the same cycle:
//     data first, mem_we=1111, mem_addr=0x00000010, stall_o=1111; the fetch is issued after the ack plus one bubble.
//  3. flush 1 cycle after a fetch request, ack 2 cycles later with 0x12345678:
//     state goes to I_DRAIN; no inst_valid; stall_o=0 from the flush cycle.
//  4. No ack with TIMEOUT=16: bus_err pulses at count 16; mem_req=0 the next cycle; FSM in IDLE.
//  5. ice with iaddr=0x00000002: no mem_req; inst_valid=1 with inst=0; stall_o=0.
//  6. cpu_rst_n pulled low during D_WAIT: mem_req and stall_o go to 0 asynchronously; state=IDLE after release.

Source files
------------

// File: rtl/imem_dmem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package imem_dmem_port_arbiter_pkg;

  localparam int STALL_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_D_WAIT  = 2'd1,
    ARB_I_WAIT  = 2'd2,
    ARB_I_DRAIN = 2'd3
  } arb_state_e;

  localparam logic [STALL_W-1:0] STALL_NONE = 4'b0000;
  localparam logic [STALL_W-1:0] STALL_ALL  = 4'b1111;
  localparam logic [STALL_W-1:0] STALL_IF   = 4'b0011;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/imem_dmem_port_arbiter_wait_timer.sv
// Cycle counter for an outstanding bus request; expire flags the timeout limit.
module arb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count;

  assign expire = (count == 8'(TIMEOUT));

  // Holds at the limit so expire stays stable until the next request clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && !expire) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access,
// data first, with pipeline stall generation, flush draining and a bus timeout.
module imem_dmem_port_arbiter
  import imem_dmem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK = 32'h1fff_ffff,
  parameter int          TIMEOUT   = 16
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic               ice,
  input  logic [31:0]        iaddr,
  output logic [31:0]        inst,
  output logic               inst_valid,
  input  logic               dce,
  input  logic [3:0]         dwe,
  input  logic [31:0]        daddr,
  input  logic [31:0]        din,
  output logic [31:0]        dm,
  output logic               dm_valid,
  input  logic               flush,
  output logic [STALL_W-1:0] stall_o,
  output logic               bus_err,
  output logic               mem_req,
  output logic [3:0]         mem_we,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ack
);

  arb_state_e state;
  logic       expire;
  logic       start_d, start_i, done, to_drain;
  logic       is_load;

  assign is_load = (mem_we == 4'b0000);

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (cpu_clk_50M),
    .rst_n  (cpu_rst_n),
    .clear  (start_d | start_i | to_drain),
    .enable (mem_req),
    .expire (expire)
  );

  // Stall and result paths are combinational so the pipeline reacts in the
  // request cycle and captures data in the same cycle the stall releases.
  always_comb begin
    start_d    = 1'b0;
    start_i    = 1'b0;
    done       = 1'b0;
    to_drain   = 1'b0;
    stall_o    = STALL_NONE;
    inst       = 32'd0;
    inst_valid = 1'b0;
    dm         = 32'd0;
    dm_valid   = 1'b0;
    bus_err    = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (dce) begin
          start_d = 1'b1;
          stall_o = STALL_ALL;
        end else if (ice) begin
          if (word_aligned(iaddr)) begin
            start_i = 1'b1;
            stall_o = STALL_IF;
          end else begin
            inst_valid = 1'b1;
          end
        end
      end
      ARB_D_WAIT: begin
        if (mem_ack) begin
          done     = 1'b1;
          dm_valid = is_load;
          dm       = is_load ? mem_rdata : 32'd0;
        end else if (expire) begin
          done     = 1'b1;
          bus_err  = 1'b1;
          dm_valid = is_load;
        end else begin
          stall_o = STALL_ALL;
        end
      end
      ARB_I_WAIT: begin
        if (mem_ack) begin
          done       = 1'b1;
          inst_valid = !flush;
          inst       = flush ? 32'd0 : mem_rdata;
        end else if (expire) begin
          done       = 1'b1;
          bus_err    = 1'b1;
          inst_valid = !flush;
        end else if (flush) begin
          to_drain = 1'b1;
        end else begin
          stall_o = STALL_IF;
        end
      end
      ARB_I_DRAIN: begin
        if (mem_ack) begin
          done = 1'b1;
        end else if (expire) begin
          done    = 1'b1;
          bus_err = 1'b1;
        end
      end
      default: ;
    endcase
    if (!cpu_rst_n) begin
      start_d    = 1'b0;
      start_i    = 1'b0;
      done       = 1'b0;
      to_drain   = 1'b0;
      stall_o    = STALL_NONE;
      inst       = 32'd0;
      inst_valid = 1'b0;
      dm         = 32'd0;
      dm_valid   = 1'b0;
      bus_err    = 1'b0;
    end
  end

  // A request, once issued, stays on the bus until ack or timeout.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else if (start_d) begin
      state     <= ARB_D_WAIT;
      mem_req   <= 1'b1;
      mem_we    <= dwe;
      mem_addr  <= daddr & ADDR_MASK;
      mem_wdata <= din;
    end else if (start_i) begin
      state    <= ARB_I_WAIT;
      mem_req  <= 1'b1;
      mem_we   <= 4'b0000;
      mem_addr <= iaddr & ADDR_MASK;
    end else if (done) begin
      state   <= ARB_IDLE;
      mem_req <= 1'b0;
    end else if (to_drain) begin
      state <= ARB_I_DRAIN;
    end
  end

endmodule
